// File: rtl/io_port_responder_if.sv
// CPU I/O bus between the execute stage (master) and the port responder (slave).
// Carries the port address, write data and strobe, read data, and the interrupt request/ack pair.
interface io_port_responder_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strobe;
  logic [7:0] in_port;
  logic       int_ack;
  logic       interrupt;

  modport master (
    output port_id, out_port, io_strobe, int_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, io_strobe, int_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/io_port_responder.sv
// Peripheral-side I/O port responder: output registers, synchronized input ports, and an
// edge-triggered interrupt controller that drives the single CPU interrupt line.
module io_port_responder #(
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  OUT_BASE    = 8'h40,
  parameter logic [7:0]  IN_BASE     = 8'h20,
  parameter logic [7:0]  IRQ_STAT_ID = 8'hF0,
  parameter logic [7:0]  IRQ_MASK_ID = 8'hF1,
  parameter logic [7:0]  IRQ_CLR_ID  = 8'hF2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  io_port_responder_if.slave    bus,
  input  logic [8*NUM_IN-1:0]   ext_in,
  output logic [8*NUM_OUT-1:0]  ext_out,
  input  logic [NUM_IRQ-1:0]    irq_src
);

  localparam int unsigned IN_W  = 8 * NUM_IN;
  localparam int unsigned OUT_W = 8 * NUM_OUT;

  function automatic bit overlap(int unsigned a, int unsigned an, int unsigned b, int unsigned bn);
    return (a < b + bn) && (b < a + an);
  endfunction

  localparam int unsigned OB = 32'(OUT_BASE);
  localparam int unsigned IB = 32'(IN_BASE);
  localparam int unsigned SB = 32'(IRQ_STAT_ID);
  localparam int unsigned MB = 32'(IRQ_MASK_ID);
  localparam int unsigned CB = 32'(IRQ_CLR_ID);

  localparam bit IDS_OVERLAP =
      overlap(OB, NUM_OUT, IB, NUM_IN) ||
      overlap(OB, NUM_OUT, SB, 1) || overlap(OB, NUM_OUT, MB, 1) || overlap(OB, NUM_OUT, CB, 1) ||
      overlap(IB, NUM_IN, SB, 1)  || overlap(IB, NUM_IN, MB, 1)  || overlap(IB, NUM_IN, CB, 1)  ||
      overlap(SB, 1, MB, 1) || overlap(SB, 1, CB, 1) || overlap(MB, 1, CB, 1);

  localparam bit PARAMS_BAD =
      (NUM_IRQ < 1) || (NUM_IRQ > 8) || (SYNC_STAGES < 2) || (NUM_OUT < 1) || (NUM_IN < 1) ||
      (OB + NUM_OUT > 256) || (IB + NUM_IN > 256);

  if (IDS_OVERLAP) begin : g_id_overlap
    $error("io_port_responder: port ID ranges overlap");
  end
  if (PARAMS_BAD) begin : g_param_bad
    $error("io_port_responder: parameter out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERV} state_e;

  logic [SYNC_STAGES-1:0][IN_W-1:0]    ext_sync_q;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] irq_sync_q;
  logic [SYNC_STAGES:0]                arm_q;
  logic [NUM_IRQ-1:0]                  prev_q;
  logic [NUM_IRQ-1:0]                  pending_q, pending_d;
  logic [NUM_IRQ-1:0]                  mask_q, mask_d;
  logic [OUT_W-1:0]                    out_q, out_d;
  logic [7:0]                          in_port_q, in_port_d;
  logic [NUM_IRQ-1:0]                  clr;
  logic [NUM_IRQ-1:0]                  rise;
  logic [IN_W-1:0]                     ext_synced;
  logic [NUM_IRQ-1:0]                  irq_synced;
  logic                                armed;
  logic                                req;
  state_e                              state_q;
  logic                                interrupt_q;

  assign ext_synced = ext_sync_q[SYNC_STAGES-1];
  assign irq_synced = irq_sync_q[SYNC_STAGES-1];
  // Detection arms only once the synchronizer holds real pin samples, so a source high at reset is not an edge
  assign armed      = arm_q[SYNC_STAGES];
  assign req        = |(pending_q & mask_q);

  // Bus decode: register writes, W1C, edge capture, and read-data mux
  always_comb begin
    mask_d    = mask_q;
    clr       = '0;
    out_d     = out_q;
    in_port_d = 8'h00;

    if (bus.io_strobe) begin
      if (bus.port_id == IRQ_MASK_ID) mask_d = bus.out_port[NUM_IRQ-1:0];
      if (bus.port_id == IRQ_CLR_ID)  clr    = bus.out_port[NUM_IRQ-1:0];
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (bus.port_id == 8'(OB + k)) out_d[8*k +: 8] = bus.out_port;
      end
    end

    rise      = armed ? (irq_synced & ~prev_q) : '0;
    pending_d = (pending_q & ~clr) | rise;

    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.port_id == 8'(IB + k)) in_port_d = ext_synced[8*k +: 8];
    end
    if (bus.port_id == IRQ_STAT_ID) in_port_d = 8'(pending_q);
    if (bus.port_id == IRQ_MASK_ID) in_port_d = 8'(mask_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_sync_q <= '0;
      irq_sync_q <= '0;
      arm_q      <= '0;
      prev_q     <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      out_q      <= '0;
      in_port_q  <= 8'h00;
    end else begin
      ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ext_in};
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irq_src};
      arm_q      <= {arm_q[SYNC_STAGES-1:0], 1'b1};
      prev_q     <= irq_synced;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      out_q      <= out_d;
      in_port_q  <= in_port_d;
    end
  end

  // Interrupt handshake: request until acked, then hold off until software drops the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      interrupt_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q     <= ST_REQ;
            interrupt_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.int_ack) begin
            state_q     <= ST_SERV;
            interrupt_q <= 1'b0;
          end else if (!req) begin
            state_q     <= ST_IDLE;
            interrupt_q <= 1'b0;
          end
        end
        ST_SERV: begin
          if (!req) state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          interrupt_q <= 1'b0;
        end
      endcase
    end
  end

  assign ext_out       = out_q;
  assign bus.in_port   = in_port_q;
  assign bus.interrupt = interrupt_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: a cycle model built from pin-history rules is compared
// every cycle, and hand-computed literals pin the key scenarios.
module tb_io_port_responder;

  localparam int S = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] ext_in;
  logic [31:0] ext_out;
  logic [7:0]  irq_src;

  io_port_responder_if bus ();

  io_port_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ext_in  (ext_in),
    .ext_out (ext_out),
    .irq_src (irq_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the outputs must be, derived from pin histories since reset
  logic [31:0] m_ext_out;
  logic [7:0]  m_mask, m_pend, m_in, m_nxt_in, m_rise, m_clr;
  logic [7:0]  m_si, m_pi;
  logic [31:0] m_se;
  logic        m_int, m_wait_clear, m_req;
  int          n;
  int          idx;
  logic [31:0] qe[$];
  logic [7:0]  qi[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ext_out = '0; m_mask = '0; m_pend = '0; m_in = '0;
      m_int = 1'b0; m_wait_clear = 1'b0; n = 0;
      qe.delete(); qi.delete();
    end else begin
      n++;
      // Pins seen through S flops: value sampled S edges ago; edges need two valid samples
      m_se   = (n > S) ? qe[n-S-1] : '0;
      m_si   = (n > S) ? qi[n-S-1] : '0;
      m_pi   = (n > S + 1) ? qi[n-S-2] : '0;
      m_rise = (n > S + 1) ? (m_si & ~m_pi) : '0;

      m_nxt_in = 8'h00;
      idx = int'(bus.port_id) - 'h20;
      if (idx >= 0 && idx < 4) m_nxt_in = 8'(m_se >> (8 * idx));
      if (bus.port_id == 8'hF0) m_nxt_in = m_pend;
      if (bus.port_id == 8'hF1) m_nxt_in = m_mask;

      m_req = |(m_pend & m_mask);
      if (m_int) begin
        if (bus.int_ack) begin m_int = 1'b0; m_wait_clear = 1'b1; end
        else if (!m_req) m_int = 1'b0;
      end else if (m_wait_clear) begin
        if (!m_req) m_wait_clear = 1'b0;
      end else begin
        m_int = m_req;
      end

      m_clr = '0;
      if (bus.io_strobe) begin
        idx = int'(bus.port_id) - 'h40;
        if (idx >= 0 && idx < 4) m_ext_out[8*idx +: 8] = bus.out_port;
        if (bus.port_id == 8'hF1) m_mask = bus.out_port;
        if (bus.port_id == 8'hF2) m_clr = bus.out_port;
      end
      m_pend = (m_pend & ~m_clr) | m_rise;
      m_in   = m_nxt_in;
      qe.push_back(ext_in);
      qi.push_back(irq_src);
    end
  end

  always @(negedge clk) begin
    check("cyc_ext_out", ext_out, m_ext_out);
    check("cyc_in_port", 32'(bus.in_port), 32'(m_in));
    check("cyc_interrupt", 32'(bus.interrupt), 32'(m_int));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int k = 1);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    bus.port_id   = id;
    bus.out_port  = data;
    bus.io_strobe = 1'b1;
    step();
    bus.io_strobe = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ext_in = '0;
    irq_src = 8'h01;
    bus.port_id = 8'h00; bus.out_port = 8'h00; bus.io_strobe = 1'b0; bus.int_ack = 1'b0;
    step(3);
    check("rst_ext_out", ext_out, 32'h0);
    check("rst_in_port", 32'(bus.in_port), 32'h0);
    check("rst_interrupt", 32'(bus.interrupt), 32'h0);
    rst_n = 1'b1;
    step(8);
    bus.port_id = 8'hF0;
    step();
    check("high_at_release_pending", 32'(bus.in_port), 32'h00);

    // Output register write, then a non-strobed write must be ignored
    wr(8'h41, 8'h3C);
    check("out_write", 32'(ext_out[15:8]), 32'h3C);
    bus.out_port = 8'hFF;
    step();
    check("out_no_strobe", 32'(ext_out[15:8]), 32'h3C);

    // Input port latency: SYNC_STAGES+1 edges
    ext_in[7:0] = 8'h5A;
    bus.port_id = 8'h20;
    step(2);
    check("in_latency_early", 32'(bus.in_port), 32'h00);
    step();
    check("in_latency", 32'(bus.in_port), 32'h5A);
    bus.port_id = 8'h7E;
    step();
    check("in_unmapped", 32'(bus.in_port), 32'h00);

    // Asynchronous reset in the middle of a cycle
    wr(8'h40, 8'hA5);
    check("out_a5", 32'(ext_out[7:0]), 32'hA5);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_ext_out", ext_out, 32'h0);
    check("async_rst_in_port", 32'(bus.in_port), 32'h0);
    check("async_rst_interrupt", 32'(bus.interrupt), 32'h0);
    step();
    rst_n = 1'b1;
    step(6);

    // Interrupt request, ack, service hold, clear
    wr(8'hF1, 8'h04);
    irq_src = 8'h05;
    step(2);
    irq_src = 8'h01;
    step();
    check("irq_not_yet", 32'(bus.interrupt), 32'h0);
    step();
    check("irq_raised", 32'(bus.interrupt), 32'h1);
    step(2);
    check("irq_held", 32'(bus.interrupt), 32'h1);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
    check("irq_acked", 32'(bus.interrupt), 32'h0);
    step(3);
    check("irq_serv_hold", 32'(bus.interrupt), 32'h0);
    wr(8'hF2, 8'h04);
    step(3);
    check("irq_no_rerequest", 32'(bus.interrupt), 32'h0);

    // Set beats W1C on the same cycle
    irq_src = 8'h03;
    step(2);
    bus.port_id = 8'hF2; bus.out_port = 8'h02; bus.io_strobe = 1'b1;
    step();
    bus.io_strobe = 1'b0;
    bus.port_id = 8'hF0;
    step();
    check("set_beats_clear", 32'(bus.in_port), 32'h02);
    wr(8'hF2, 8'h02);

    // Masked source is visible in status but never interrupts until unmasked
    wr(8'hF1, 8'h00);
    irq_src = 8'h0B;
    step(4);
    bus.port_id = 8'hF0;
    step();
    check("masked_status", 32'(bus.in_port), 32'h08);
    check("masked_no_irq", 32'(bus.interrupt), 32'h0);
    wr(8'hF1, 8'h08);
    check("unmask_edge", 32'(bus.interrupt), 32'h0);
    step();
    check("unmask_irq", 32'(bus.interrupt), 32'h1);
    bus.port_id = 8'hF1;
    step();
    check("mask_readback", 32'(bus.in_port), 32'h08);
    wr(8'hF2, 8'h08);
    step();
    check("req_drop_idle", 32'(bus.interrupt), 32'h0);

    // All output registers and input ports
    for (int k = 0; k < 4; k++) wr(8'(8'h40 + k), 8'(8'h11 * (k + 1)));
    check("out_all", ext_out, 32'h4433_2211);
    ext_in = 32'h7788_99AA;
    step(3);
    for (int k = 0; k < 4; k++) begin
      bus.port_id = 8'(8'h20 + k);
      step();
    end
    check("in_port3", 32'(bus.in_port), 32'h77);
    bus.port_id = 8'hF2;
    step();
    check("clr_reads_zero", 32'(bus.in_port), 32'h00);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
